// File: rtl/shared_pkg.sv
// Shared FIFO definitions plus the types used by the FIFO write arbiter.
package shared_pkg;

  // Existing FIFO geometry.
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  // Default number of producers sharing the FIFO write port.
  localparam int FIFO_ARB_NUM_REQ = 4;

  // Write-arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Rotates req so that rr_ptr
// becomes bit 0, isolates the lowest set bit, then rotates the result back.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  localparam logic [NUM_REQ-1:0] ONE = 1;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] rot_dbl;
  logic [2*NUM_REQ-1:0] win_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   first;

  // Rotate right by rr_ptr: rot[k] corresponds to requester (k + rr_ptr) mod NUM_REQ.
  assign req_dbl = {req, req};
  assign rot_dbl = req_dbl >> rr_ptr;
  assign rot     = rot_dbl[NUM_REQ-1:0];

  // Lowest set bit of the rotated vector is the first requester at or after rr_ptr.
  assign first   = rot & (~rot + ONE);

  // Rotate back left by rr_ptr; the upper half holds the wrapped result.
  assign win_dbl = {first, first} << rr_ptr;
  assign winner  = win_dbl[2*NUM_REQ-1:NUM_REQ];
  assign valid   = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. One write in flight at a time (IDLE -> ISSUE -> WAIT_ACK).
// Optional per-requester saturating accepted-write counters are built only
// when the macro FIFO_ARB_CNT_EN is defined; otherwise grant_cnt reads 0.
module fifo_wr_arbiter
  import shared_pkg::*;
#(
  parameter int NUM_REQ = FIFO_ARB_NUM_REQ,
  parameter int DATA_W  = FIFO_WIDTH,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              done,
  output logic [NUM_REQ-1:0]              drop,
  output logic                            busy,
  output logic [NUM_REQ-1:0][CNT_W-1:0]   grant_cnt,
  output logic                            fifo_wr_en,
  output logic [DATA_W-1:0]               fifo_data_in,
  input  logic                            fifo_full,
  input  logic                            fifo_wr_ack,
  input  logic                            fifo_overflow
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt_q,  gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] drop_q, drop_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_valid;
  logic               arb_go;
  logic               resp_ok;
  logic [PTR_W-1:0]   gnt_idx;
  logic [DATA_W-1:0]  pick_data;

  logic [NUM_REQ:0][DATA_W-1:0] data_chain;
  logic [NUM_REQ:0][PTR_W-1:0]  idx_chain;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_oh),
    .valid  (pick_valid)
  );

  // A new write is only started from IDLE while the FIFO has room.
  assign arb_go = (state_q == IDLE) && pick_valid && !fifo_full;

  // A contradictory ack+overflow response is treated as a rejected write.
  assign resp_ok = fifo_wr_ack && !fifo_overflow;

  // Winner data mux and grant-to-index encoder, built as OR chains over the one-hot vectors.
  assign data_chain[0] = '0;
  assign idx_chain[0]  = '0;
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign data_chain[gi+1] = data_chain[gi] | (req_data[gi] & {DATA_W{pick_oh[gi]}});
      assign idx_chain[gi+1]  = idx_chain[gi] | (gnt_q[gi] ? PTR_W'(gi) : '0);
    end
  endgenerate
  assign pick_data = data_chain[NUM_REQ];
  assign gnt_idx   = idx_chain[NUM_REQ];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (arb_go) state_d = ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM output logic: grant, data latch, write strobe, completion pulses, pointer.
  always_comb begin
    gnt_d    = gnt_q;
    done_d   = '0;
    drop_d   = '0;
    wr_en_d  = 1'b0;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (arb_go) begin
          gnt_d   = pick_oh;
          data_d  = pick_data;
          wr_en_d = 1'b1;
        end
      end
      ISSUE: begin
        // The FIFO samples the write this cycle; strobe drops by default.
      end
      WAIT_ACK: begin
        if (resp_ok) begin
          done_d = gnt_q;
        end else begin
          drop_d = gnt_q;
        end
        gnt_d    = '0;
        rr_ptr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_ONE;
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  // Registered outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      done_q   <= '0;
      drop_q   <= '0;
      wr_en_q  <= 1'b0;
      data_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign drop         = drop_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign busy         = (state_q != IDLE);

`ifdef FIFO_ARB_CNT_EN
  // Per-requester accepted-write counters, saturating at all-ones.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      localparam logic [CNT_W-1:0] CNT_ONE = 1;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Count on the same edge that raises done for this requester.
      always_comb begin
        cnt_d = cnt_q;
        if (done_d[gi] && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
      end

      // Counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign grant_cnt[gi] = cnt_q;
    end
  endgenerate
`else
  assign grant_cnt = '0;
`endif

endmodule
